// File: rtl/vc_wb_buffer_if.sv
// vc_wb_buffer_if: bus bundle for the victim-cache write-back buffer.
//   enq_*    : evicted dirty line offered by the victim cache (valid/ready)
//   lookup_* : combinational probe of lines still waiting in the buffer
//   mem_*    : write request to the next level, completed by a mem_resp pulse
// slave  : the buffer side (vc_wb_buffer)
// master : the surrounding cache controller / memory side
interface vc_wb_buffer_if #(
  parameter int s_line = 256,
  parameter int s_addr = 27
);
  logic              enq_valid;
  logic              enq_ready;
  logic [s_addr-1:0] enq_addr;
  logic [s_line-1:0] enq_data;
  logic [s_addr-1:0] lookup_addr;
  logic              lookup_hit;
  logic [s_line-1:0] lookup_data;
  logic              mem_write;
  logic [s_addr-1:0] mem_address;
  logic [s_line-1:0] mem_wdata;
  logic              mem_resp;

  modport slave (
    input  enq_valid, enq_addr, enq_data, lookup_addr, mem_resp,
    output enq_ready, lookup_hit, lookup_data, mem_write, mem_address, mem_wdata
  );

  modport master (
    output enq_valid, enq_addr, enq_data, lookup_addr, mem_resp,
    input  enq_ready, lookup_hit, lookup_data, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/vc_wb_buffer.sv
// vc_wb_buffer: write-back buffer behind the victim cache data array.
// Dirty evicted lines are queued in a DEPTH-entry circular FIFO and drained
// to memory one at a time through a two-state (IDLE/WRITE) FSM. A purely
// combinational lookup port lets the controller hit on queued lines.
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : enq_* / lookup_* / mem_* handshake bundle
//   full, empty     : occupancy flags decoded from the registered count
//   count           : number of occupied entries
//
// Optional feature (macro VC_WB_COALESCE_EN): an enqueue whose address matches
// a valid entry other than the head currently being written overwrites that
// entry's data instead of allocating a new one.
module vc_wb_buffer #(
  parameter int s_line = 256,
  parameter int s_addr = 27,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  vc_wb_buffer_if.slave              bus,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, WRITE} state_t;

  typedef struct packed {
    logic [s_addr-1:0] addr;
    logic [s_line-1:0] data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    head_q, tail_q;
  state_t           state_q;
  logic             mem_write_q;

  logic             enq_fire, alloc, pop, coalesce;
  logic [AW-1:0]    coal_idx;

  // Ready depends only on registered count: a pop completing this cycle does
  // not free a slot for an enqueue in the same cycle.
  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign bus.enq_ready = !full;
  assign enq_fire      = bus.enq_valid && !full;
  assign pop           = (state_q == WRITE) && bus.mem_resp;
  assign alloc         = enq_fire && !coalesce;

  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = ent_q[head_q].addr;
  assign bus.mem_wdata   = ent_q[head_q].data;

`ifdef VC_WB_COALESCE_EN
  // Walk oldest to youngest so the youngest match wins; the head is skipped
  // while its write is in flight so the data on the memory bus stays stable.
  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    coalesce = 1'b0;
    coal_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (vld_q[idx] && ent_q[idx].addr == bus.enq_addr &&
          !(state_q == WRITE && k == 0)) begin
        coalesce = 1'b1;
        coal_idx = idx;
      end
    end
  end
`else
  assign coalesce = 1'b0;
  assign coal_idx = '0;
`endif

  // Lookup: scan from head towards tail, later (younger) matches override.
  always_comb begin
    logic [AW-1:0] idx;
    idx             = '0;
    bus.lookup_hit  = 1'b0;
    bus.lookup_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (vld_q[idx] && ent_q[idx].addr == bus.lookup_addr) begin
        bus.lookup_hit  = 1'b1;
        bus.lookup_data = ent_q[idx].data;
      end
    end
  end

  // Line storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (enq_fire) ent_q[coalesce ? coal_idx : tail_q] <= {bus.enq_addr, bus.enq_data};
  end

  // Pointers, valid bits, count and drain FSM. alloc and pop never target the
  // same slot: tail == head with entries present means full, which blocks alloc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count       <= '0;
      vld_q       <= '0;
      state_q     <= IDLE;
      mem_write_q <= 1'b0;
    end else begin
      if (alloc) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      case ({alloc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Returning to IDLE on each response guarantees a low mem_write cycle
      // between consecutive writes.
      case (state_q)
        IDLE: if (count != '0) begin
          state_q     <= WRITE;
          mem_write_q <= 1'b1;
        end
        WRITE: if (bus.mem_resp) begin
          state_q     <= IDLE;
          mem_write_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vc_wb_buffer.sv
// tb_vc_wb_buffer: directed table-driven bench for vc_wb_buffer.
// Each vector drives inputs just after a rising edge, checks outputs once they
// settle (before the next edge), then lets the edge happen. Expected counts in
// the duplicate-address part depend on VC_WB_COALESCE_EN.
module tb_vc_wb_buffer;
  localparam int SL = 256;
  localparam int SA = 27;
  localparam int D  = 4;
`ifdef VC_WB_COALESCE_EN
  localparam bit CO = 1'b1;
`else
  localparam bit CO = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       full, empty;
  logic [2:0] count;
  int         total, bad;

  vc_wb_buffer_if #(.s_line(SL), .s_addr(SA)) bus ();

  vc_wb_buffer #(.s_line(SL), .s_addr(SA), .DEPTH(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ev;
    logic [SA-1:0] ea;
    logic [7:0]    ed;
    logic          rsp;
    logic [SA-1:0] la;
    int            cnt;
    logic          mw;
    logic [SA-1:0] ma;
    logic [7:0]    wd;
    logic          hit;
    logic [7:0]    hd;
  } vec_t;

  vec_t tv[$];

  function automatic logic [SL-1:0] mkd(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic vec_t mkv(input logic ev, input int ea, input logic [7:0] ed,
                               input logic rsp, input int la, input int cnt,
                               input logic mw, input int ma, input logic [7:0] wd,
                               input logic hit, input logic [7:0] hd);
    vec_t v;
    v.ev = ev; v.ea = SA'(ea); v.ed = ed; v.rsp = rsp; v.la = SA'(la);
    v.cnt = cnt; v.mw = mw; v.ma = SA'(ma); v.wd = wd; v.hit = hit; v.hd = hd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [SA-1:0] ea, input logic [7:0] ed,
                       input logic rsp, input logic [SA-1:0] la);
    bus.enq_valid   = ev;
    bus.enq_addr    = ea;
    bus.enq_data    = mkd(ed);
    bus.mem_resp    = rsp;
    bus.lookup_addr = la;
  endtask

  task automatic chk_occ(input string p, input int c);
    chk({p, ".count"},     SL'(count),         SL'(c));
    chk({p, ".full"},      SL'(full),          SL'(c == D));
    chk({p, ".empty"},     SL'(empty),         SL'(c == 0));
    chk({p, ".enq_ready"}, SL'(bus.enq_ready), SL'(c != D));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, '0, 8'h00, 1'b0, '0);

    // Write-path latency, stable head data, idle response ignored.
    tv.push_back(mkv(1, 'h10, 'hA5, 0, 'h10, 0, 0, 0,    0,     0, 0));
    tv.push_back(mkv(0, 0,    0,    0, 'h10, 1, 0, 0,    0,     1, 'hA5));
    tv.push_back(mkv(0, 0,    0,    0, 'h10, 1, 1, 'h10, 'hA5,  1, 'hA5));
    tv.push_back(mkv(0, 0,    0,    0, 'h10, 1, 1, 'h10, 'hA5,  1, 'hA5));
    tv.push_back(mkv(0, 0,    0,    1, 'h10, 1, 1, 'h10, 'hA5,  1, 'hA5));
    tv.push_back(mkv(0, 0,    0,    1, 'h10, 0, 0, 0,    0,     0, 0));
    // Fill to full, blocked fifth enqueue, pop+enqueue collision, in-order drain.
    tv.push_back(mkv(1, 1, 'h11, 0, 9, 0, 0, 0, 0,     0, 0));
    tv.push_back(mkv(1, 2, 'h22, 0, 1, 1, 0, 0, 0,     1, 'h11));
    tv.push_back(mkv(1, 3, 'h33, 0, 2, 2, 1, 1, 'h11,  1, 'h22));
    tv.push_back(mkv(1, 4, 'h44, 0, 3, 3, 1, 1, 'h11,  1, 'h33));
    tv.push_back(mkv(1, 5, 'h55, 0, 9, 4, 1, 1, 'h11,  0, 0));
    tv.push_back(mkv(1, 5, 'h55, 1, 1, 4, 1, 1, 'h11,  1, 'h11));
    tv.push_back(mkv(1, 5, 'h55, 0, 5, 3, 0, 0, 0,     0, 0));
    tv.push_back(mkv(0, 0, 0,    0, 5, 4, 1, 2, 'h22,  1, 'h55));
    tv.push_back(mkv(0, 0, 0,    1, 1, 4, 1, 2, 'h22,  0, 0));
    tv.push_back(mkv(0, 0, 0,    0, 2, 3, 0, 0, 0,     0, 0));
    tv.push_back(mkv(0, 0, 0,    1, 4, 3, 1, 3, 'h33,  1, 'h44));
    tv.push_back(mkv(0, 0, 0,    0, 3, 2, 0, 0, 0,     0, 0));
    tv.push_back(mkv(0, 0, 0,    1, 4, 2, 1, 4, 'h44,  1, 'h44));
    tv.push_back(mkv(0, 0, 0,    0, 4, 1, 0, 0, 0,     0, 0));
    tv.push_back(mkv(0, 0, 0,    1, 5, 1, 1, 5, 'h55,  1, 'h55));
    tv.push_back(mkv(0, 0, 0,    0, 5, 0, 0, 0, 0,     0, 0));
    // Duplicate addresses while head 0x1 is being written.
    tv.push_back(mkv(1, 1, 'h11, 0, 9, 0,          0, 0, 0,    0, 0));
    tv.push_back(mkv(0, 0, 0,    0, 1, 1,          0, 0, 0,    1, 'h11));
    tv.push_back(mkv(1, 7, 'hAA, 0, 7, 1,          1, 1, 'h11, 0, 0));
    tv.push_back(mkv(1, 7, 'hBB, 0, 7, 2,          1, 1, 'h11, 1, 'hAA));
    tv.push_back(mkv(0, 0, 0,    0, 7, CO ? 2 : 3, 1, 1, 'h11, 1, 'hBB));
    tv.push_back(mkv(1, 1, 'hCC, 0, 1, CO ? 2 : 3, 1, 1, 'h11, 1, 'h11));
    tv.push_back(mkv(0, 0, 0,    0, 1, CO ? 3 : 4, 1, 1, 'h11, 1, 'hCC));

    // Reset state.
    #12;
    chk_occ("reset", 0);
    chk("reset.mem_write",  SL'(bus.mem_write),  SL'(1'b0));
    chk("reset.lookup_hit", SL'(bus.lookup_hit), SL'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      string p;
      p = $sformatf("v%0d", i);
      drive(tv[i].ev, tv[i].ea, tv[i].ed, tv[i].rsp, tv[i].la);
      #1;
      chk_occ(p, tv[i].cnt);
      chk({p, ".mem_write"}, SL'(bus.mem_write), SL'(tv[i].mw));
      if (tv[i].mw) begin
        chk({p, ".mem_address"}, SL'(bus.mem_address), SL'(tv[i].ma));
        chk({p, ".mem_wdata"},   bus.mem_wdata,        mkd(tv[i].wd));
      end
      chk({p, ".lookup_hit"},  SL'(bus.lookup_hit), SL'(tv[i].hit));
      chk({p, ".lookup_data"}, bus.lookup_data,     mkd(tv[i].hd));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a WRITE: takes effect between edges.
    drive(1'b0, '0, 8'h00, 1'b0, SA'(1));
    #1;
    chk("prerst.mem_write", SL'(bus.mem_write), SL'(1'b1));
    #1;
    rst = 1'b0;
    #1;
    chk("midrst.mem_write",  SL'(bus.mem_write),  SL'(1'b0));
    chk_occ("midrst", 0);
    chk("midrst.lookup_hit", SL'(bus.lookup_hit), SL'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst%0d.mem_write", c), SL'(bus.mem_write), SL'(1'b0));
      chk($sformatf("postrst%0d.count", c),     SL'(count),         SL'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
